// File: rtl/seq_cover_monitor_if.sv
// Signal bundle between the x/y/z producers and the sequence cover monitor.
// master drives the terms and controls; slave (the monitor) returns hit/count/status.
interface seq_cover_monitor_if #(
  parameter int CNT_W = 16
) ();
  logic             en;
  logic             clr;
  logic             x;
  logic             y;
  logic             z;
  logic             hit;
  logic [CNT_W-1:0] hit_count;
  logic             overflow;
  logic             busy;

  modport master (
    output en, clr, x, y, z,
    input  hit, hit_count, overflow, busy
  );

  modport slave (
    input  en, clr, x, y, z,
    output hit, hit_count, overflow, busy
  );
endinterface

// File: rtl/seq_cover_monitor.sv
// Hardware cover of x ##DELAY1 y[*MIN_REP:MAX_REP] ##DELAY2 z; hit pulses 1 cycle after the closing z.
// No backpressure: terms are sampled every cycle, outputs are a pulse, a saturating count and status levels.
module seq_cover_monitor #(
  parameter int DELAY1  = 2,
  parameter int DELAY2  = 1,
  parameter int MIN_REP = 3,
  parameter int MAX_REP = 4,
  parameter int CNT_W   = 16
) (
  input logic                clk,
  input logic                rst_n,
  seq_cover_monitor_if.slave mon
);

  logic [DELAY1:1]  xs;
  logic [MAX_REP:1] r;
  logic [MAX_REP:1] run;
  logic [DELAY2:1]  zs;
  logic             xd;
  logic             zd;
  logic             done;
  logic             hit_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  assign xd = xs[DELAY1];
  assign zd = zs[DELAY2];

  // run[j]: some attempt has now seen exactly j consecutive y's; the top slot never feeds forward.
  always_comb begin
    run    = '0;
    run[1] = xd & mon.y;
    for (int j = 2; j <= MAX_REP; j++) begin
      run[j] = r[j-1] & mon.y;
    end
    done = |run[MAX_REP:MIN_REP];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || mon.clr) begin
      xs    <= '0;
      r     <= '0;
      zs    <= '0;
      hit_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      xs[1] <= mon.x & mon.en;
      for (int i = 2; i <= DELAY1; i++) begin
        xs[i] <= xs[i-1];
      end
      r     <= run;
      zs[1] <= done;
      for (int i = 2; i <= DELAY2; i++) begin
        zs[i] <= zs[i-1];
      end
      hit_q <= zd & mon.z;
      // Simultaneous completions collapse into a single count.
      if (zd & mon.z) begin
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_q <= cnt_q + 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign mon.hit       = hit_q;
  assign mon.hit_count = cnt_q;
  assign mon.overflow  = ovf_q;
  assign mon.busy      = (|xs) | (|r) | (|zs);

endmodule

// File: tb/tb_seq_cover_monitor.sv
// Randomized and directed bench for seq_cover_monitor, scoreboarded against a history-based sequence model.
// Two monitors share stimulus: default counter width and a 2-bit counter for saturation.
module tb_seq_cover_monitor;
  localparam int D1   = 2;
  localparam int D2   = 1;
  localparam int MINR = 3;
  localparam int MAXR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, clr = 1'b0, x = 1'b0, y = 1'b0, z = 1'b0;

  always #5 clk = ~clk;

  seq_cover_monitor_if #(.CNT_W(16)) ifa ();
  seq_cover_monitor_if #(.CNT_W(2))  ifb ();

  assign ifa.en = en;  assign ifa.clr = clr;
  assign ifa.x = x;    assign ifa.y = y;    assign ifa.z = z;
  assign ifb.en = en;  assign ifb.clr = clr;
  assign ifb.x = x;    assign ifb.y = y;    assign ifb.z = z;

  seq_cover_monitor #(.DELAY1(D1), .DELAY2(D2), .MIN_REP(MINR), .MAX_REP(MAXR), .CNT_W(16))
    dut (.clk(clk), .rst_n(rst_n), .mon(ifa.slave));
  seq_cover_monitor #(.DELAY1(D1), .DELAY2(D2), .MIN_REP(MINR), .MAX_REP(MAXR), .CNT_W(2))
    dut_sat (.clk(clk), .rst_n(rst_n), .mon(ifb.slave));

  typedef struct {
    int cyc;
    bit hit;
    int hits;
    bit busy;
  } exp_t;

  exp_t sb[$];
  bit   xh[$];
  bit   yh[$];
  bit   zh[$];
  int   base = -1;
  int   cyc = 0;
  int   hits = 0;
  int   n_total = 0;
  int   n_pass = 0;

  // An attempt started at s that sees exactly n consecutive y's from s+D1, all after the last clear.
  function automatic bit run_ok(int s, int n);
    if (s <= base || s < 0) return 1'b0;
    if (!xh[s]) return 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!yh[s+D1+k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit done_at(int d);
    for (int n = MINR; n <= MAXR; n++) begin
      if (run_ok(d - D1 - n + 1, n)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Anything still pending after the edge of cycle c: an x waiting, a partial y run, or a done waiting for z.
  function automatic bit busy_at(int c);
    for (int s = c - D1 + 1; s <= c; s++) begin
      if (s > base && s >= 0 && xh[s]) return 1'b1;
    end
    for (int j = 1; j <= MAXR; j++) begin
      if (run_ok(c - D1 - j + 1, j)) return 1'b1;
    end
    for (int d = c - D2 + 1; d <= c; d++) begin
      if (done_at(d)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check(string name, int c, int act, int expv);
    n_total++;
    if (act == expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, act, expv);
    end
  endtask

  task automatic step(bit xi, bit yi, bit zi, bit eni, bit clri, bit rsti_n);
    exp_t e;
    @(negedge clk);
    x = xi; y = yi; z = zi; en = eni; clr = clri; rst_n = rsti_n;
    xh.push_back(xi & eni);
    yh.push_back(yi);
    zh.push_back(zi);
    e.cyc = cyc;
    if (!rsti_n || clri) begin
      base   = cyc;
      hits   = 0;
      e.hit  = 1'b0;
      e.busy = 1'b0;
    end else begin
      e.hit = zi && done_at(cyc - D2);
      if (e.hit) hits++;
      e.busy = busy_at(cyc);
    end
    e.hits = hits;
    sb.push_back(e);
    cyc++;
  endtask

  // Bit i of each mask is the value in pattern cycle i.
  task automatic pat(input logic [15:0] xp, input logic [15:0] yp, input logic [15:0] zp,
                     input logic [15:0] enp, input logic [15:0] clrp, input logic [15:0] rstp);
    for (int i = 0; i < 16; i++) begin
      step(xp[i], yp[i], zp[i], enp[i], clrp[i], !rstp[i]);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("hit",        e.cyc, int'(ifa.hit),       int'(e.hit));
        check("hit_count",  e.cyc, int'(ifa.hit_count), (e.hits > 65535) ? 65535 : e.hits);
        check("overflow",   e.cyc, int'(ifa.overflow),  int'(e.hits > 65535));
        check("busy",       e.cyc, int'(ifa.busy),      int'(e.busy));
        check("sat_count",  e.cyc, int'(ifb.hit_count), (e.hits > 3) ? 3 : e.hits);
        check("sat_ovf",    e.cyc, int'(ifb.overflow),  int'(e.hits > 3));
        check("sat_hit",    e.cyc, int'(ifb.hit),       int'(e.hit));
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    // basic, max reps, 5 y's, too few, overlap
    pat(16'h0001, 16'h001C, 16'h0020, 16'hFFFF, 16'h0000, 16'h0000);
    pat(16'h0001, 16'h003C, 16'h0040, 16'hFFFF, 16'h0000, 16'h0000);
    pat(16'h0001, 16'h007C, 16'h0080, 16'hFFFF, 16'h0000, 16'h0000);
    pat(16'h0001, 16'h000C, 16'h0070, 16'hFFFF, 16'h0000, 16'h0000);
    pat(16'h0003, 16'h007C, 16'h00C0, 16'hFFFF, 16'h0000, 16'h0000);
    // en low, clr mid-flight, reset mid-flight
    pat(16'h0001, 16'h001C, 16'h0020, 16'h0000, 16'h0000, 16'h0000);
    pat(16'h0001, 16'h001C, 16'h0020, 16'hFFFF, 16'h0010, 16'h0000);
    pat(16'h0001, 16'h001C, 16'h0020, 16'hFFFF, 16'h0000, 16'h0010);
    // saturation of the narrow counter, then clear
    step(0, 0, 0, 1, 1, 1);
    for (int k = 0; k < 5; k++) begin
      pat(16'h0001, 16'h001C, 16'h0020, 16'hFFFF, 16'h0000, 16'h0000);
    end
    pat(16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 90, $urandom_range(0, 199) == 0, $urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    @(posedge clk);
    #2;
    check("sb_drain", cyc, sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
